uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the processor data bus, a peer of `dmem`: it decodes `dataadr`/`memwrite`/`writedata` from `mips` and serialises bytes on `tx`. Bytes written by the CPU are queued in a small FIFO. They are sent as 8N1 frames at a fixed clocks-per-bit rate. Status and control registers are readable through `readdata`, and `top` muxes that onto the CPU read path when `sel` is high.

---
 rtl/uart_tx_mmio.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_tx_mmio #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        sel,
   output logic        tx,
   output logic        txbusy
);

   localparam int unsigned c_aw = $clog2(FIFO_DEPTH);
   localparam int unsigned c_cw = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned c_bw = $clog2(CLKS_PER_BIT);
   localparam logic [c_bw-1:0] c_baud_last  = c_bw'(CLKS_PER_BIT - 1);
   localparam logic [c_cw-1:0] c_full_cnt   = c_cw'(FIFO_DEPTH);
   localparam logic [1:0]      c_reg_txdata = 2'd0;
   localparam logic [1:0]      c_reg_status = 2'd1;
   localparam logic [1:0]      c_reg_ctrl   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } t_state;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_aw-1:0] r_wr, r_rd;
   logic [c_cw-1:0] r_count;
   logic            r_ovf, r_en;
   t_state          r_state, w_state_n;
   logic [c_bw-1:0] r_baud, w_baud_n;
   logic [2:0]      r_bit, w_bit_n;
   logic [7:0]      r_sh, w_sh_n;
   logic            r_tx, w_tx_n;

   logic        w_we, w_push_req, w_push, w_pop, w_full, w_empty, w_active;
   logic [1:0]  w_reg;
   logic [31:0] w_status;
   logic        w_unused;

   assign sel        = (dataadr[31:4] == BASE_ADDR[31:4]);
   assign w_reg      = dataadr[3:2];
   assign w_we       = memwrite && sel;
   assign w_push_req = w_we && (w_reg == c_reg_txdata);
   assign w_full     = (r_count == c_full_cnt);
   assign w_empty    = (r_count == '0);
   assign w_active   = (r_state != S_IDLE);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_unused   = ^{writedata[31:8], dataadr[1:0]};

   assign w_status = {24'h0, 4'(r_count), r_ovf, w_active, w_empty, w_full};
   assign tx       = r_tx;
   assign txbusy   = w_active || !w_empty;

   always_comb begin
      readdata = '0;
      case (w_reg)
         c_reg_status: readdata = w_status;
         c_reg_ctrl:   readdata = {31'h0, r_en};
         default:      readdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= writedata[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_en    <= 1'b1;
      end else begin
         if (w_push) r_wr <= r_wr + c_aw'(1);
         if (w_pop)  r_rd <= r_rd + c_aw'(1);
         r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
         if (w_we && (w_reg == c_reg_status))
            r_ovf <= 1'b0;
         else if (w_push_req && !w_push)
            r_ovf <= 1'b1;
         if (w_we && (w_reg == c_reg_ctrl))
            r_en <= writedata[0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_baud  <= w_baud_n;
         r_bit   <= w_bit_n;
         r_sh    <= w_sh_n;
         r_tx    <= w_tx_n;
      end
   end

   // tx is registered, so each state sets the level for the following cycle.
   always_comb begin
      w_state_n = r_state;
      w_baud_n  = r_baud;
      w_bit_n   = r_bit;
      w_sh_n    = r_sh;
      w_tx_n    = r_tx;
      w_pop     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_n = 1'b1;
            if (r_en && !w_empty) begin
               w_pop     = 1'b1;
               w_sh_n    = r_mem[r_rd];
               w_baud_n  = '0;
               w_tx_n    = 1'b0;
               w_state_n = S_START;
            end
         end
         S_START: begin
            if (r_baud == c_baud_last) begin
               w_baud_n  = '0;
               w_bit_n   = '0;
               w_tx_n    = r_sh[0];
               w_state_n = S_DATA;
            end else begin
               w_baud_n = r_baud + c_bw'(1);
            end
         end
         S_DATA: begin
            if (r_baud == c_baud_last) begin
               w_baud_n = '0;
               if (r_bit == 3'd7) begin
                  w_tx_n    = 1'b1;
                  w_state_n = S_STOP;
               end else begin
                  w_bit_n = r_bit + 3'd1;
                  w_sh_n  = {1'b0, r_sh[7:1]};
                  w_tx_n  = r_sh[1];
               end
            end else begin
               w_baud_n = r_baud + c_bw'(1);
            end
         end
         S_STOP: begin
            if (r_baud == c_baud_last) begin
               w_baud_n  = '0;
               w_tx_n    = 1'b1;
               w_state_n = S_IDLE;
            end else begin
               w_baud_n = r_baud + c_bw'(1);
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_uart_tx_mmio;

   localparam int unsigned CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic        sel, tx, txbusy;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4),
      .BASE_ADDR    (32'hFFFF_FF00)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .readdata  (readdata),
      .sel       (sel),
      .tx        (tx),
      .txbusy    (txbusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      @(negedge clk);
      memwrite  = 1'b0;
      writedata = 32'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      memwrite = 1'b0;
      dataadr  = a;
      #1;
      d = readdata;
   endtask

   // Waits for a start bit, then samples 40 cycles of tx against the 8N1 frame.
   task automatic expect_frame(input string tag, input logic [7:0] b, output int waited);
      logic [39:0] obs;
      logic [39:0] exp;
      logic        v;
      waited = 0;
      while (tx !== 1'b0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      v = 1'b0;
         else if (k == 9) v = 1'b1;
         else             v = b[k-1];
         for (int j = 0; j < 4; j++) exp[4*k+j] = v;
      end
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         obs[i] = tx;
      end
      chk(tag, 64'(obs), 64'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  bytes [5];
      int          w;
      int          zeros;

      // Reset
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_tx", 64'(tx), 64'd1);
      chk("rst_busy", 64'(txbusy), 64'd0);
      rd(32'hFFFF_FF04, d); chk("rst_status", 64'(d), 64'h02);
      rd(32'hFFFF_FF08, d); chk("rst_ctrl", 64'(d), 64'h01);
      rd(32'hFFFF_FF00, d); chk("rd_txdata", 64'(d), 64'h00);
      rd(32'hFFFF_FF0C, d); chk("rd_reg3", 64'(d), 64'h00);
      rd(32'hFFFF_FF07, d); chk("rd_lsb_ignored", 64'(d), 64'h02);
      rd(32'hFFFF_FF08, d); chk("sel_hit", 64'(sel), 64'd1);
      rd(32'hFFFF_FE08, d); chk("sel_miss", 64'(sel), 64'd0);

      // Single byte
      wr(32'hFFFF_FF00, 32'hA5);
      chk("single_pre_tx", 64'(tx), 64'd1);
      rd(32'hFFFF_FF04, d); chk("single_status_q", 64'(d), 64'h10);
      expect_frame("single_frame", 8'hA5, w);
      chk("single_latency", 64'(w), 64'd1);
      @(negedge clk);
      chk("single_busy_end", 64'(txbusy), 64'd0);
      rd(32'hFFFF_FF04, d); chk("single_status_end", 64'(d), 64'h02);

      // Overflow
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
      wr(32'hFFFF_FF08, 32'h0);
      for (int i = 0; i < 5; i++) wr(32'hFFFF_FF00, {24'h0, bytes[i]});
      rd(32'hFFFF_FF04, d); chk("ovf_status", 64'(d), 64'h49);
      wr(32'hFFFF_FF04, 32'hDEAD_BEEF);
      rd(32'hFFFF_FF04, d); chk("ovf_cleared", 64'(d), 64'h41);
      wr(32'hFFFF_FF08, 32'h1);
      for (int i = 0; i < 4; i++) begin
         expect_frame($sformatf("ovf_frame%0d", i), bytes[i], w);
         chk($sformatf("ovf_gap%0d", i), 64'(w), (i == 0) ? 64'd1 : 64'd2);
      end
      zeros = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      chk("ovf_no_fifth", 64'(zeros), 64'd0);
      chk("ovf_busy_end", 64'(txbusy), 64'd0);
      rd(32'hFFFF_FF04, d); chk("ovf_status_end", 64'(d), 64'h02);

      // Back-to-back writes on consecutive edges
      @(negedge clk);
      memwrite = 1'b1; dataadr = 32'hFFFF_FF00; writedata = 32'h00;
      @(negedge clk);
      writedata = 32'hFF;
      @(negedge clk);
      memwrite = 1'b0; writedata = 32'h0;
      expect_frame("b2b_frame0", 8'h00, w);
      chk("b2b_latency", 64'(w), 64'd0);
      expect_frame("b2b_frame1", 8'hFF, w);
      chk("b2b_gap", 64'(w), 64'd2);
      chk("b2b_total", 64'(40 + (w - 1) + 40), 64'd81);

      // Push on the exact edge of a pop with the FIFO full
      wr(32'hFFFF_FF08, 32'h0);
      for (int i = 0; i < 4; i++) wr(32'hFFFF_FF00, 32'hC1 + i);
      rd(32'hFFFF_FF04, d); chk("coll_full", 64'(d), 64'h41);
      @(negedge clk);
      memwrite = 1'b1; dataadr = 32'hFFFF_FF08; writedata = 32'h1;
      @(negedge clk);
      dataadr = 32'hFFFF_FF00; writedata = 32'hC5;
      @(negedge clk);
      memwrite = 1'b0; writedata = 32'h0;
      rd(32'hFFFF_FF04, d); chk("coll_status", 64'(d), 64'h45);
      for (int i = 0; i < 5; i++) begin
         expect_frame($sformatf("coll_frame%0d", i), 8'(8'hC1 + i), w);
         chk($sformatf("coll_gap%0d", i), 64'(w), (i == 0) ? 64'd0 : 64'd2);
      end
      @(negedge clk);
      chk("coll_busy_end", 64'(txbusy), 64'd0);

      // Reset mid-frame during data bit 3
      wr(32'hFFFF_FF00, 32'h07);
      w = 0;
      while (tx !== 1'b0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("rmf_latency", 64'(w), 64'd1);
      wr(32'hFFFF_FF00, 32'h99);
      rd(32'hFFFF_FF04, d); chk("rmf_status_q", 64'(d), 64'h14);
      repeat (16) @(negedge clk);
      chk("rmf_bit3_low", 64'(tx), 64'd0);
      reset = 1'b0;
      #1;
      chk("rmf_tx_async", 64'(tx), 64'd1);
      chk("rmf_busy_async", 64'(txbusy), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rd(32'hFFFF_FF04, d); chk("rmf_status", 64'(d), 64'h02);
      zeros = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      chk("rmf_tx_idle", 64'(zeros), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
